quick_cpu_seq: RTL and testbench
================================

QUICK_CPU_SEQ -- requirements
Module: quick_cpu_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have port cmd_valid, input, 1, command request.
REQ-004 SHALL have port cmd_ready, output, 1, command acceptance; a command executes only in a cycle with cmd_valid && cmd_ready.
REQ-005 SHALL have port cmd_op, input, 2, command opcode: 00 LOAD, 01 RUN, 10 STEP, 11 HALT.
REQ-006 SHALL have port cmd_data, input, 8, LOAD payload.
REQ-007 SHALL have port pc, output, 4, program counter.
REQ-008 SHALL have port inst, output, 8, registered current instruction to datapath.
REQ-009 SHALL have port exec_valid, output, 1, one-cycle strobe: datapath executes inst this cycle.
REQ-010 SHALL have port busy, output, 1, high in FETCH or EXEC.
REQ-011 SHALL have port halted, output, 1, high in HALTED.

Function
REQ-012 SHALL hold a 16x8 instruction memory, load pointer ldptr (4 bit), run_mode flag.
REQ-013 SHALL implement FSM states IDLE, FETCH, EXEC, HALTED.
REQ-014 SHALL drive cmd_ready = 1 in every state outside reset.
REQ-015 IDLE + LOAD: mem[ldptr] <= cmd_data, ldptr <= ldptr+1 wrapping 15->0; state stays IDLE.
REQ-016 IDLE + RUN: run_mode <= 1, -> FETCH, pc retained (resume).
REQ-017 IDLE + STEP: run_mode <= 0, -> FETCH.
REQ-018 IDLE + HALT: pc <= 0, ldptr <= 0, stay IDLE (program rewind).
REQ-019 FETCH: inst <= mem[pc], -> EXEC; exactly 1 cycle.
REQ-020 EXEC, inst == 8'hFF: -> HALTED, pc unchanged, exec_valid = 0.
REQ-021 EXEC, inst[7:6] == 2'b11 and inst != 8'hFF: jump, pc <= inst[3:0], exec_valid = 0.
REQ-022 EXEC, otherwise: exec_valid = 1 this cycle, pc <= pc+1 wrapping 15->0.
REQ-023 EXEC exit (non-halt): run_mode=1 -> FETCH, run_mode=0 -> IDLE; steady throughput 1 instruction per 2 cycles.
REQ-024 FETCH/EXEC + HALT command: -> IDLE, exec_valid forced 0, pc and inst unchanged; HALT wins over any EXEC action in the same cycle.
REQ-025 FETCH/EXEC + LOAD/RUN/STEP: accepted, no effect.
REQ-026 HALTED + HALT command: pc <= 0, -> IDLE; all other ops accepted, no effect.
REQ-027 exec_valid SHALL be combinational from state==EXEC and decode, never high outside EXEC.

Reset
REQ-028 rst_n low at a clock edge: state IDLE, pc 0, ldptr 0, inst 0, run_mode 0, all memory words 8'h00, regardless of current state.
REQ-029 During reset cycles cmd_ready, exec_valid, busy, halted SHALL be 0; commands are ignored.
REQ-030 Reset mid-RUN SHALL produce no exec_valid pulse in or after the reset cycle until a new RUN/STEP.

Structure
REQ-031 Package quick_cpu_pkg SHALL hold the state enum, cmd_op codes, INST_HALT = 8'hFF, JMP prefix 2'b11, IMEM_DEPTH = 16.
REQ-032 Instruction memory SHALL be sub-module quick_cpu_imem (16x8, sync write, async read, sync clear on reset).
REQ-033 Target size 120-400 lines RTL total.

Verification
REQ-034 LOAD 8'h01,8'h02,8'hFF; RUN -> exec_valid pulses with inst 01 then 02, then halted=1 with pc=2, no third pulse.
REQ-035 LOAD 8'h10, 8'hC0 (jmp 0); RUN 12 cycles -> exec_valid pulses every 4 cycles with inst 10 only, pc alternates 0/1.
REQ-036 LOAD 8'h05,8'h06; STEP -> one exec_valid with inst 05, back to IDLE pc=1; STEP -> inst 06, pc=2.
REQ-037 17 LOADs 8'h00..8'h10 -> mem[0]=8'h10 (wrap), mem[1]=8'h01; STEP executes 8'h10.
REQ-038 RUN non-halting program, assert HALT command in an EXEC cycle -> exec_valid 0 that cycle, state IDLE, pc unchanged; RUN resumes at same pc.
REQ-039 rst_n low for 1 cycle mid-RUN -> next cycle IDLE, pc 0, memory reads 8'h00, no exec_valid.

Source files
------------

// File: rtl/quick_cpu_pkg.sv
// quick_cpu_pkg: shared types and constants for the quick_cpu sequencer.
//   state_e  - sequencer FSM states
//   cmd_op_e - command opcodes on cmd_op
//   INST_HALT / JMP_PREFIX - instruction decode constants
//   IMEM_DEPTH / IMEM_AW / INST_W - instruction memory geometry
package quick_cpu_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_AW    = 4;
  localparam int INST_W     = 8;

  localparam logic [INST_W-1:0] INST_HALT  = 8'hFF;
  localparam logic [1:0]        JMP_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } cmd_op_e;

  // Jump = JMP prefix on the top two bits, excluding the halt encoding.
  function automatic logic is_jump(input logic [INST_W-1:0] i);
    return (i[7:6] == JMP_PREFIX) && (i != INST_HALT);
  endfunction

endpackage

// File: rtl/quick_cpu_imem.sv
// quick_cpu_imem: 16x8 instruction memory.
//   clk, rst_n - clock, synchronous active-low reset (clears every word)
//   we_i, waddr_i, wdata_i - synchronous write port
//   raddr_i, rdata_o - asynchronous read port
module quick_cpu_imem
  import quick_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IMEM_AW-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [IMEM_AW-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < IMEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/quick_cpu_seq.sv
// quick_cpu_seq: command-driven instruction sequencer.
//   clk, rst_n       - clock, synchronous active-low reset
//   cmd_valid/ready  - command handshake; cmd_op selects LOAD/RUN/STEP/HALT
//   cmd_data         - LOAD payload written at the load pointer
//   pc, inst         - program counter and registered current instruction
//   exec_valid       - datapath executes inst this cycle
//   busy, halted     - FETCH/EXEC and HALTED status
module quick_cpu_seq
  import quick_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [INST_W-1:0] cmd_data,
  output logic [IMEM_AW-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              exec_valid,
  output logic              busy,
  output logic              halted
);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [IMEM_AW-1:0] ldptr_q, ldptr_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               run_q, run_d;
  logic               mem_we;
  logic [INST_W-1:0]  mem_rdata;
  logic               exec_int;
  logic               fire;
  logic               halt_cmd;

  quick_cpu_imem u_imem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (ldptr_q),
    .wdata_i (cmd_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  // Ready is simply "not in reset"; every state accepts commands.
  assign cmd_ready = rst_n;
  assign fire      = cmd_valid && cmd_ready;
  assign halt_cmd  = fire && (cmd_op == OP_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ldptr_q <= '0;
      inst_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ldptr_q <= ldptr_d;
      inst_q  <= inst_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ldptr_d  = ldptr_q;
    inst_d   = inst_q;
    run_d    = run_q;
    mem_we   = 1'b0;
    exec_int = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          unique case (cmd_op)
            OP_LOAD: begin
              mem_we  = 1'b1;
              ldptr_d = ldptr_q + 1'b1;
            end
            OP_RUN: begin
              run_d   = 1'b1;
              state_d = ST_FETCH;
            end
            OP_STEP: begin
              run_d   = 1'b0;
              state_d = ST_FETCH;
            end
            default: begin // OP_HALT: rewind program and load pointer
              pc_d    = '0;
              ldptr_d = '0;
            end
          endcase
        end
      end
      ST_FETCH: begin
        if (halt_cmd) begin
          state_d = ST_IDLE;
        end else begin
          inst_d  = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // A HALT command overrides whatever the instruction would do.
        if (halt_cmd) begin
          state_d = ST_IDLE;
        end else if (inst_q == INST_HALT) begin
          state_d = ST_HALTED;
        end else begin
          if (is_jump(inst_q)) begin
            pc_d = inst_q[IMEM_AW-1:0];
          end else begin
            exec_int = 1'b1;
            pc_d     = pc_q + 1'b1;
          end
          state_d = run_q ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin // ST_HALTED
        if (halt_cmd) begin
          pc_d    = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Status outputs are gated by rst_n so they read 0 during the reset cycle
  // even though the state register still holds its pre-reset value.
  assign exec_valid = rst_n && exec_int;
  assign busy       = rst_n && ((state_q == ST_FETCH) || (state_q == ST_EXEC));
  assign halted     = rst_n && (state_q == ST_HALTED);
  assign pc         = pc_q;
  assign inst       = inst_q;

endmodule

// File: tb/tb_quick_cpu_seq.sv
module tb_quick_cpu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       exec_valid;
  logic       busy;
  logic       halted;

  localparam logic [1:0] LD = 2'b00, RN = 2'b01, ST = 2'b10, HT = 2'b11;

  int n_chk  = 0;
  int n_pass = 0;

  // pulse log filled by watch()
  int         pcnt;
  logic [7:0] pinst [16];
  logic [3:0] ppc   [16];
  int         pcyc  [16];

  quick_cpu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .pc         (pc),
    .inst       (inst),
    .exec_valid (exec_valid),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Sample n cycles on the falling edge and log exec_valid pulses.
  task automatic watch(input int n);
    pcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exec_valid && pcnt < 16) begin
        pinst[pcnt] = inst;
        ppc[pcnt]   = pc;
        pcyc[pcnt]  = i;
        pcnt++;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_pc", pc, 0);
    chk("idle_inst", inst, 0);
    chk("idle_halted", halted, 0);

    // 01, 02, FF: two pulses then halt at pc 2
    cmd(LD, 8'h01); cmd(LD, 8'h02); cmd(LD, 8'hFF);
    cmd(RN, 8'h00);
    watch(8);
    chk("halt_pulses", pcnt, 2);
    chk("halt_inst0", pinst[0], 8'h01);
    chk("halt_inst1", pinst[1], 8'h02);
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 2);
    chk("halt_busy", busy, 0);
    // non-HALT ops ignored while halted; HALT rewinds pc and returns to IDLE
    cmd(RN, 8'h00);
    @(negedge clk);
    chk("halted_ign", halted, 1);
    cmd(HT, 8'h00);
    @(negedge clk);
    chk("unhalt_halted", halted, 0);
    chk("unhalt_pc", pc, 0);
    chk("unhalt_busy", busy, 0);

    // 10, C0: jump loop, pulse every 4 cycles with inst 10 at pc 0
    do_reset();
    cmd(LD, 8'h10); cmd(LD, 8'hC0);
    cmd(RN, 8'h00);
    watch(12);
    chk("jmp_pulses", pcnt, 3);
    chk("jmp_inst0", pinst[0], 8'h10);
    chk("jmp_inst2", pinst[2], 8'h10);
    chk("jmp_pc1", ppc[1], 0);
    chk("jmp_gap", pcyc[1] - pcyc[0], 4);
    chk("jmp_gap2", pcyc[2] - pcyc[1], 4);
    cmd(HT, 8'h00);

    // STEP twice
    do_reset();
    cmd(LD, 8'h05); cmd(LD, 8'h06);
    cmd(ST, 8'h00);
    watch(4);
    chk("step1_pulses", pcnt, 1);
    chk("step1_inst", pinst[0], 8'h05);
    chk("step1_pc", pc, 1);
    chk("step1_busy", busy, 0);
    cmd(ST, 8'h00);
    watch(4);
    chk("step2_pulses", pcnt, 1);
    chk("step2_inst", pinst[0], 8'h06);
    chk("step2_pc", pc, 2);

    // 17 loads: the 17th wraps onto address 0
    do_reset();
    for (int i = 0; i < 17; i++) cmd(LD, 8'(i));
    cmd(ST, 8'h00);
    watch(4);
    chk("wrap_pulses", pcnt, 1);
    chk("wrap_mem0", pinst[0], 8'h10);
    cmd(ST, 8'h00);
    watch(4);
    chk("wrap_mem1", pinst[0], 8'h01);

    // HALT command during EXEC
    do_reset();
    cmd(LD, 8'h01); cmd(LD, 8'h02); cmd(LD, 8'h03); cmd(LD, 8'h04);
    cmd(RN, 8'h00);
    watch(3); // FETCH, EXEC(01), FETCH; next negedge is EXEC(02)
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = HT;
    #1;
    chk("hx_busy_exec", busy, 1);
    chk("hx_exec_valid", exec_valid, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hx_busy", busy, 0);
    chk("hx_pc", pc, 1);
    chk("hx_inst", inst, 8'h02);
    cmd(RN, 8'h00);
    watch(2);
    chk("hx_resume_inst", pinst[0], 8'h02);
    chk("hx_resume_pc", ppc[0], 1);
    cmd(HT, 8'h00);

    // reset for one cycle while running
    do_reset();
    cmd(LD, 8'h01); cmd(LD, 8'h02); cmd(LD, 8'h03);
    cmd(RN, 8'h00);
    watch(3);
    rst_n = 1'b0;
    #1;
    chk("mr_ready", cmd_ready, 0);
    chk("mr_exec", exec_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    watch(6);
    chk("mr_no_pulse", pcnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pc", pc, 0);
    chk("mr_inst", inst, 0);
    cmd(ST, 8'h00);
    watch(4);
    chk("mr_step_pulses", pcnt, 1);
    chk("mr_mem_clear", pinst[0], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
